// File: rtl/bdf_prog_sequencer_if.sv
// Control/status bundle between the host and bdf_prog_sequencer, plus the
// flag/strobe lines to the dataflow buffer array.
interface bdf_prog_sequencer_if #(
  parameter int CODE_LENGTH     = 64,
  parameter int NUM_BUFFERS     = 12,
  parameter int CODE_WIDTH      = NUM_BUFFERS * 2,
  parameter int ITERATION_BOUND = 64
);
  localparam int PC_W  = $clog2(CODE_LENGTH);
  localparam int LEN_W = $clog2(CODE_LENGTH) + 1;
  localparam int IT_W  = $clog2(ITERATION_BOUND) + 1;

  logic                   start;
  logic [LEN_W-1:0]       prog_len;
  logic [IT_W-1:0]        iter_count;
  logic                   prog_we;
  logic [PC_W-1:0]        prog_addr;
  logic [CODE_WIDTH-1:0]  prog_wdata;
  logic [NUM_BUFFERS-1:0] buf_empty;
  logic [NUM_BUFFERS-1:0] buf_full;
  logic [NUM_BUFFERS-1:0] buf_pop;
  logic [NUM_BUFFERS-1:0] buf_push;
  logic                   busy;
  logic                   done;
  logic [PC_W-1:0]        pc;
  logic [IT_W-1:0]        iter;
  logic [15:0]            stall_cnt;

  modport master (
    output start, prog_len, iter_count, prog_we, prog_addr, prog_wdata,
           buf_empty, buf_full,
    input  buf_pop, buf_push, busy, done, pc, iter, stall_cnt
  );

  modport slave (
    input  start, prog_len, iter_count, prog_we, prog_addr, prog_wdata,
           buf_empty, buf_full,
    output buf_pop, buf_push, busy, done, pc, iter, stall_cnt
  );
endinterface

// File: rtl/bdf_prog_sequencer.sv
// Program-driven sequencer for the dataflow buffers. Steps a loadable
// microprogram (2-bit command per buffer per word) for a number of
// iterations, firing pop/push strobes only when the whole word can proceed.
module bdf_prog_sequencer #(
  parameter int CODE_LENGTH     = 64,
  parameter int NUM_BUFFERS     = 12,
  parameter int CODE_WIDTH      = NUM_BUFFERS * 2,
  parameter int ITERATION_BOUND = 64
) (
  input  logic                clk,
  input  logic                reset,
  bdf_prog_sequencer_if.slave bus
);
  localparam int PC_W  = $clog2(CODE_LENGTH);
  localparam int LEN_W = $clog2(CODE_LENGTH) + 1;
  localparam int IT_W  = $clog2(ITERATION_BOUND) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state;
  logic [LEN_W-1:0]       len_q;
  logic [IT_W-1:0]        cnt_q;
  logic [PC_W-1:0]        pc_q;
  logic [IT_W-1:0]        iter_q;
  logic [15:0]            stall_q;
  logic [CODE_WIDTH-1:0]  instr_p1;
  logic [CODE_WIDTH-1:0]  mem [CODE_LENGTH];

  logic [NUM_BUFFERS-1:0] pop_req;
  logic [NUM_BUFFERS-1:0] push_req;
  logic                   word_ready;
  logic                   exec_fire;
  logic                   last_word;
  logic                   last_iter;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
    return (v > LEN_W'(CODE_LENGTH)) ? LEN_W'(CODE_LENGTH) : v;
  endfunction

  function automatic logic [IT_W-1:0] clamp_iter(input logic [IT_W-1:0] v);
    return (v > IT_W'(ITERATION_BOUND)) ? IT_W'(ITERATION_BOUND) : v;
  endfunction

  // Program store write port; the store is never cleared and only loads while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state == S_IDLE))
      mem[bus.prog_addr] <= bus.prog_wdata;
  end

  // ---- stage p1: instruction register, loaded from the store during FETCH ----
  always_ff @(posedge clk) begin
    if (state == S_FETCH)
      instr_p1 <= mem[pc_q];
  end

  // Decode the current word and AND together every field's flag condition.
  always_comb begin
    pop_req    = '0;
    push_req   = '0;
    word_ready = 1'b1;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      pop_req[i]  = instr_p1[2*i];
      push_req[i] = instr_p1[2*i+1];
      if ((instr_p1[2*i] && bus.buf_empty[i]) || (instr_p1[2*i+1] && bus.buf_full[i]))
        word_ready = 1'b0;
    end
  end

  assign exec_fire = (state == S_EXEC) && word_ready;
  assign last_word = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
  assign last_iter = ((iter_q + IT_W'(1)) == cnt_q);

  // Run control: IDLE -> FETCH <-> EXEC -> DONE -> IDLE, with pc/iter/stall bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      iter_q  <= '0;
      stall_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len_q   <= clamp_len(bus.prog_len);
            cnt_q   <= clamp_iter(bus.iter_count);
            pc_q    <= '0;
            iter_q  <= '0;
            stall_q <= '0;
            state   <= ((bus.prog_len == '0) || (bus.iter_count == '0)) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (word_ready) begin
            if (last_word) begin
              pc_q   <= '0;
              iter_q <= iter_q + IT_W'(1);
              state  <= last_iter ? S_DONE : S_FETCH;
            end else begin
              pc_q  <= pc_q + PC_W'(1);
              state <= S_FETCH;
            end
          end else begin
            stall_q <= sat_inc16(stall_q);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.buf_pop   = exec_fire ? pop_req  : '0;
  assign bus.buf_push  = exec_fire ? push_req : '0;
  assign bus.busy      = (state == S_FETCH) || (state == S_EXEC);
  assign bus.done      = (state == S_DONE);
  assign bus.pc        = pc_q;
  assign bus.iter      = iter_q;
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_bdf_prog_sequencer.sv
// Bench for bdf_prog_sequencer: reset check, table of single-word runs,
// hand-written multi-cycle sequences, and randomized runs against a
// word-schedule reference model.
module tb_bdf_prog_sequencer;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bdf_prog_sequencer_if bus();

  bdf_prog_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] word;
    logic [11:0] empty;
    logic [11:0] full;
    logic [11:0] pop;
    logic [11:0] push;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] mdl_mem [64];
  logic [11:0] fl_empty [MAXC];
  logic [11:0] fl_full  [MAXC];
  logic [11:0] obs_pop  [MAXC];
  logic [11:0] obs_push [MAXC];
  int          obs_done_cyc;
  int          obs_busy_cnt;
  int          obs_strobe_cnt;
  int          obs_iter_done;
  int          obs_stall_done;

  bit          rnd_flags;
  bit          rnd_stray;
  int          wr_cyc;
  int          rst_cyc;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] rflags();
    return 12'($urandom & $urandom & $urandom);
  endfunction

  task automatic drive_defaults();
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.prog_len   = '0;
    bus.iter_count = '0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.buf_empty  = '0;
    bus.buf_full   = '0;
  endtask

  task automatic clear_opts();
    rnd_flags = 1'b0;
    rnd_stray = 1'b0;
    wr_cyc    = -1;
    rst_cyc   = -1;
    wr_addr   = '0;
    wr_data   = '0;
    for (int c = 0; c < MAXC; c++) begin
      fl_empty[c] = '0;
      fl_full[c]  = '0;
    end
  endtask

  task automatic load(input int a, input logic [23:0] d);
    @(negedge clk);
    drive_defaults();
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 6'(a);
    bus.prog_wdata = d;
    mdl_mem[a]     = d;
    @(negedge clk);
    drive_defaults();
  endtask

  // One run: cycle 0 presents start; the model predicts, word by word, when
  // each EXEC happens, whether it fires, and when done pulses.
  task automatic run(input int len_in, input int cnt_in, input int max_c);
    int len, cnt, total, k, next_exec, done_c, stalls;
    int exp_pc, exp_iter;
    bit exp_busy, exp_done, rdy, finished;
    logic [23:0] w;
    logic [11:0] fe, ff, pop_m, push_m, e_pop, e_push;

    len      = (len_in > 64) ? 64 : len_in;
    cnt      = (cnt_in > 64) ? 64 : cnt_in;
    total    = len * cnt;
    done_c   = (total == 0) ? 1 : -1;
    k        = 0;
    next_exec = 2;
    stalls   = 0;
    finished = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      obs_pop[c]  = '0;
      obs_push[c] = '0;
    end
    obs_done_cyc   = -1;
    obs_busy_cnt   = 0;
    obs_strobe_cnt = 0;
    obs_iter_done  = -1;
    obs_stall_done = -1;

    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      cyc = c;
      fe = rnd_flags ? rflags() : fl_empty[c];
      ff = rnd_flags ? rflags() : fl_full[c];
      bus.buf_empty  = fe;
      bus.buf_full   = ff;
      reset          = (c == rst_cyc);
      bus.start      = (c == 0) || (c == wr_cyc) || (rnd_stray && c > 0 && $urandom_range(0, 9) == 0);
      bus.prog_len   = (c == 0) ? 7'(len_in) : 7'($urandom_range(1, 64));
      bus.iter_count = (c == 0) ? 7'(cnt_in) : 7'($urandom_range(1, 64));
      bus.prog_we    = (c == wr_cyc) || (rnd_stray && c > 0 && $urandom_range(0, 9) == 0);
      bus.prog_addr  = (c == wr_cyc) ? wr_addr : 6'($urandom);
      bus.prog_wdata = (c == wr_cyc) ? wr_data : 24'($urandom);
      #1;

      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        check("abort_pop",   32'(bus.buf_pop),   0);
        check("abort_push",  32'(bus.buf_push),  0);
        check("abort_busy",  32'(bus.busy),      0);
        check("abort_done",  32'(bus.done),      0);
        check("abort_pc",    32'(bus.pc),        0);
        check("abort_iter",  32'(bus.iter),      0);
        check("abort_stall", 32'(bus.stall_cnt), 0);
        finished = 1'b1;
        break;
      end

      exp_pc   = (len == 0) ? 0 : k % len;
      exp_iter = (len == 0) ? 0 : k / len;
      exp_busy = (c >= 1) && (done_c < 0 || c < done_c);
      exp_done = (c == done_c);
      e_pop    = '0;
      e_push   = '0;
      if (done_c < 0 && c == next_exec) begin
        w = mdl_mem[k % len];
        for (int i = 0; i < 12; i++) begin
          pop_m[i]  = w[2*i];
          push_m[i] = w[2*i+1];
        end
        rdy = ((pop_m & fe) == 12'h000) && ((push_m & ff) == 12'h000);
        if (rdy) begin
          e_pop  = pop_m;
          e_push = push_m;
          k++;
          if (k == total) done_c = c + 1;
          else next_exec = c + 2;
        end else begin
          stalls++;
          next_exec = c + 1;
        end
      end

      check("buf_pop",  32'(bus.buf_pop),  32'(e_pop));
      check("buf_push", 32'(bus.buf_push), 32'(e_push));
      check("busy",     32'(bus.busy),     32'(exp_busy));
      check("done",     32'(bus.done),     32'(exp_done));
      if (c >= 1) begin
        check("pc",        32'(bus.pc),        exp_pc);
        check("iter",      32'(bus.iter),      exp_iter);
        check("stall_cnt", 32'(bus.stall_cnt), (stalls - ((rdy == 1'b0 && c + 1 == next_exec && c >= 2 && done_c < 0) ? 1 : 0)));
      end

      obs_pop[c]  = bus.buf_pop;
      obs_push[c] = bus.buf_push;
      if (bus.busy) obs_busy_cnt++;
      if ((bus.buf_pop | bus.buf_push) != 12'h000) obs_strobe_cnt++;
      if (bus.done && obs_done_cyc < 0) begin
        obs_done_cyc   = c;
        obs_iter_done  = int'(bus.iter);
        obs_stall_done = int'(bus.stall_cnt);
      end
      rdy = 1'b1;
      if (c == done_c) begin
        finished = 1'b1;
        break;
      end
    end
    check("run_completed", 32'(finished), 1);

    @(negedge clk);
    drive_defaults();
    #1;
    check("post_busy", 32'(bus.busy), 0);
    check("post_done", 32'(bus.done), 0);
  endtask

  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cnt;
    drive_defaults();
    clear_opts();
    for (int a = 0; a < 64; a++) mdl_mem[a] = '0;

    tbl[0] = '{24'h000001, 12'h000, 12'h000, 12'h001, 12'h000};
    tbl[1] = '{24'h000002, 12'hFFF, 12'h000, 12'h000, 12'h001};
    tbl[2] = '{24'h000003, 12'h000, 12'h000, 12'h001, 12'h001};
    tbl[3] = '{24'hC00000, 12'h7FF, 12'h7FF, 12'h800, 12'h800};
    tbl[4] = '{24'h555555, 12'h000, 12'hFFF, 12'hFFF, 12'h000};
    tbl[5] = '{24'hAAAAAA, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
    tbl[6] = '{24'h000000, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    tbl[7] = '{24'h000004, 12'h001, 12'h000, 12'h002, 12'h000};

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pop",   32'(bus.buf_pop),   0);
    check("rst_push",  32'(bus.buf_push),  0);
    check("rst_busy",  32'(bus.busy),      0);
    check("rst_done",  32'(bus.done),      0);
    check("rst_pc",    32'(bus.pc),        0);
    check("rst_iter",  32'(bus.iter),      0);
    check("rst_stall", 32'(bus.stall_cnt), 0);
    reset = 1'b0;

    // Table of single-word, single-iteration runs under static flags
    for (int t = 0; t < 8; t++) begin
      clear_opts();
      for (int c = 0; c < 16; c++) begin
        fl_empty[c] = tbl[t].empty;
        fl_full[c]  = tbl[t].full;
      end
      load(0, tbl[t].word);
      run(1, 1, 20);
      check("tbl_pop",  32'(obs_pop[2]),  32'(tbl[t].pop));
      check("tbl_push", 32'(obs_push[2]), 32'(tbl[t].push));
      check("tbl_done_cycle", obs_done_cyc, 3);
    end

    // Pop buf0, len 1, count 3
    clear_opts();
    load(0, 24'h000001);
    run(1, 3, 40);
    check("seq1_pop_c2", 32'(obs_pop[2]), 32'h001);
    check("seq1_pop_c4", 32'(obs_pop[4]), 32'h001);
    check("seq1_pop_c6", 32'(obs_pop[6]), 32'h001);
    check("seq1_strobes", obs_strobe_cnt, 3);
    check("seq1_done_cycle", obs_done_cyc, 7);
    check("seq1_iter", obs_iter_done, 3);
    check("seq1_stall", obs_stall_done, 0);

    // Push buf0 blocked by full for 5 EXEC cycles
    clear_opts();
    for (int c = 2; c <= 6; c++) fl_full[c] = 12'h001;
    load(0, 24'h000002);
    run(1, 1, 40);
    check("seq2_push_c7", 32'(obs_push[7]), 32'h001);
    check("seq2_strobes", obs_strobe_cnt, 1);
    check("seq2_stall", obs_stall_done, 5);
    check("seq2_done_cycle", obs_done_cyc, 8);

    // Pop+push buf11 blocked by full, then released
    clear_opts();
    for (int c = 2; c <= 4; c++) fl_full[c] = 12'h800;
    load(0, 24'hC00000);
    run(1, 1, 40);
    check("seq3_pop_c5", 32'(obs_pop[5]), 32'h800);
    check("seq3_push_c5", 32'(obs_push[5]), 32'h800);
    check("seq3_strobes", obs_strobe_cnt, 1);
    check("seq3_stall", obs_stall_done, 3);

    // Zero counts and clamped count
    clear_opts();
    run(1, 0, 10);
    check("zero_cnt_done_cycle", obs_done_cyc, 1);
    check("zero_cnt_busy", obs_busy_cnt, 0);
    check("zero_cnt_strobes", obs_strobe_cnt, 0);
    run(0, 5, 10);
    check("zero_len_done_cycle", obs_done_cyc, 1);
    load(0, 24'h000001);
    run(1, 100, 400);
    check("clamp_iter", obs_iter_done, 64);
    check("clamp_done_cycle", obs_done_cyc, 129);
    check("clamp_strobes", obs_strobe_cnt, 64);

    // Mid-run start pulse and program write are both ignored
    clear_opts();
    wr_cyc  = 3;
    wr_addr = 6'd0;
    wr_data = 24'h000002;
    run(1, 4, 60);
    check("midrun_done_cycle", obs_done_cyc, 9);
    check("midrun_strobes", obs_strobe_cnt, 4);
    clear_opts();
    run(1, 1, 20);
    check("readback_pop", 32'(obs_pop[2]), 32'h001);
    check("readback_push", 32'(obs_push[2]), 32'h000);

    // Reset during EXEC of the second iteration, then a clean rerun
    clear_opts();
    rst_cyc = 4;
    run(1, 3, 40);
    check("abort_strobe_c4", 32'(obs_pop[4]), 32'h001);
    check("abort_no_done", obs_done_cyc, -1);
    clear_opts();
    run(1, 3, 40);
    check("rerun_done_cycle", obs_done_cyc, 7);
    check("rerun_strobes", obs_strobe_cnt, 3);

    // Randomized programs, flags and stray host activity
    for (int r = 0; r < 20; r++) begin
      clear_opts();
      len = $urandom_range(1, 8);
      cnt = $urandom_range(1, 4);
      for (int a = 0; a < len; a++) load(a, 24'($urandom & $urandom_range(0, 3) * 24'h555555 | 24'($urandom) & 24'h0000F0));
      rnd_flags = 1'b1;
      rnd_stray = 1'b1;
      run(len, cnt, 3000);
      check("rnd_iter", obs_iter_done, cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
